// File: rtl/can_tx_mailbox.sv
// Transmit mailbox for a CAN node: buffers host frames, hands the lowest-ID
// pending frame to the node on request, and retires on success or retry limit.
module can_tx_mailbox #(
    parameter int DATA_SIZE = 64,
    parameter int ID_SIZE   = 11,
    parameter int DEPTH     = 4,
    parameter int MAX_RETRY = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [ID_SIZE-1:0]           wr_id,
    input  logic [DATA_SIZE-1:0]         wr_data,
    input  logic                         data_in_req,
    output logic [DATA_SIZE-1:0]         In_packet,
    output logic [ID_SIZE-1:0]           Tx_ID,
    output logic                         tx_pending,
    output logic                         in_flight,
    input  logic                         Retransmit,
    input  logic                         tx_done,
    output logic                         sent_pulse,
    output logic                         drop_pulse,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]                valid;
    logic [DEPTH-1:0]                pend;
    logic [DEPTH-1:0][ID_SIZE-1:0]   id_q;
    logic [DEPTH-1:0][DATA_SIZE-1:0] data_q;
    logic [DEPTH-1:0][7:0]           retry_q;
    logic [IDX_W-1:0]                sel_idx;

    logic                            best_found;
    logic [IDX_W-1:0]                best_idx;
    logic [ID_SIZE-1:0]              best_id;
    logic [IDX_W-1:0]                free_idx;
    logic [OCC_W-1:0]                occ;

    // Strict '<' keeps the lowest index on equal IDs.
    always_comb begin
        pend       = '0;
        best_found = 1'b0;
        best_idx   = '0;
        best_id    = '0;
        free_idx   = '0;
        occ        = '0;
        for (int i = DEPTH-1; i >= 0; i--)
            if (!valid[i]) free_idx = IDX_W'(i);
        for (int i = 0; i < DEPTH; i++) begin
            pend[i] = valid[i] && !(in_flight && sel_idx == IDX_W'(i));
            occ     = occ + OCC_W'(valid[i]);
            if (pend[i] && (!best_found || id_q[i] < best_id)) begin
                best_found = 1'b1;
                best_idx   = IDX_W'(i);
                best_id    = id_q[i];
            end
        end
    end

    assign wr_ready   = ~&valid;
    assign tx_pending = |pend;
    assign occupancy  = occ;

    logic       wr_fire, hand_ev, done_ev, retx_ev, drop_ev;
    logic [7:0] retry_next;

    assign wr_fire    = wr_valid && wr_ready;
    assign hand_ev    = data_in_req && !in_flight && tx_pending;
    assign done_ev    = in_flight && tx_done;
    assign retx_ev    = in_flight && Retransmit && !tx_done;
    assign retry_next = retry_q[sel_idx] + 8'd1;
    assign drop_ev    = retx_ev && (retry_next == 8'(MAX_RETRY));

    // A write always lands in a free slot, so it never collides with the retiring one.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                valid[i]   <= 1'b0;
                id_q[i]    <= '0;
                data_q[i]  <= '0;
                retry_q[i] <= '0;
            end else if (wr_fire && free_idx == IDX_W'(i)) begin
                valid[i]   <= 1'b1;
                id_q[i]    <= wr_id;
                data_q[i]  <= wr_data;
                retry_q[i] <= '0;
            end else if (sel_idx == IDX_W'(i) && (done_ev || drop_ev)) begin
                valid[i]   <= 1'b0;
            end else if (sel_idx == IDX_W'(i) && retx_ev) begin
                retry_q[i] <= retry_next;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            in_flight  <= 1'b0;
            sel_idx    <= '0;
            In_packet  <= '0;
            Tx_ID      <= '0;
            sent_pulse <= 1'b0;
            drop_pulse <= 1'b0;
        end else begin
            sent_pulse <= done_ev;
            drop_pulse <= drop_ev;
            if (hand_ev) begin
                in_flight <= 1'b1;
                sel_idx   <= best_idx;
                In_packet <= data_q[best_idx];
                Tx_ID     <= best_id;
            end else if (done_ev || retx_ev) begin
                in_flight <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_can_tx_mailbox.sv
// Directed bench for can_tx_mailbox: a frame-list model checked every cycle,
// plus literal expectations from hand-worked scenarios.
module tb_can_tx_mailbox;
    localparam int DS = 64, IS = 11, DEPTH = 4, MAXR = 8;

    logic          clock = 1'b0, reset = 1'b0;
    logic          wr_valid = 1'b0, data_in_req = 1'b0, Retransmit = 1'b0, tx_done = 1'b0;
    logic [IS-1:0] wr_id = '0;
    logic [DS-1:0] wr_data = '0;
    logic          wr_ready, tx_pending, in_flight, sent_pulse, drop_pulse;
    logic [DS-1:0] In_packet;
    logic [IS-1:0] Tx_ID;
    logic [2:0]    occupancy;

    can_tx_mailbox #(.DATA_SIZE(DS), .ID_SIZE(IS), .DEPTH(DEPTH), .MAX_RETRY(MAXR)) dut (
        .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_id(wr_id), .wr_data(wr_data), .data_in_req(data_in_req),
        .In_packet(In_packet), .Tx_ID(Tx_ID), .tx_pending(tx_pending),
        .in_flight(in_flight), .Retransmit(Retransmit), .tx_done(tx_done),
        .sent_pulse(sent_pulse), .drop_pulse(drop_pulse), .occupancy(occupancy));

    always #5 clock = ~clock;

    int checks = 0, failures = 0;
    bit checking = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: frames live in numbered slots; a frame is either pending or the one handed over.
    bit          m_used [DEPTH];
    int          m_id   [DEPTH];
    logic [63:0] m_dat  [DEPTH];
    int          m_fail [DEPTH];
    bit          m_busy;
    int          m_cur;
    int          m_txid;
    logic [63:0] m_pkt;
    bit          m_sent, m_drop;

    function automatic int pick_next();
        int b = -1;
        for (int i = 0; i < DEPTH; i++)
            if (m_used[i] && !(m_busy && m_cur == i) && (b < 0 || m_id[i] < m_id[b])) b = i;
        return b;
    endfunction

    function automatic int first_free();
        for (int i = 0; i < DEPTH; i++) if (!m_used[i]) return i;
        return -1;
    endfunction

    function automatic int count_used();
        int n = 0;
        foreach (m_used[i]) n += int'(m_used[i]);
        return n;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_used[i] <= 1'b0; m_fail[i] <= 0;
            end
            m_busy <= 1'b0; m_cur <= 0; m_txid <= 0; m_pkt <= '0;
            m_sent <= 1'b0; m_drop <= 1'b0;
        end else begin
            int nx, fr;
            nx = pick_next();
            fr = first_free();
            m_sent <= 1'b0;
            m_drop <= 1'b0;
            if (wr_valid && fr >= 0) begin
                m_used[fr] <= 1'b1; m_id[fr] <= int'(wr_id);
                m_dat[fr] <= wr_data; m_fail[fr] <= 0;
            end
            if (m_busy && tx_done) begin
                m_used[m_cur] <= 1'b0; m_busy <= 1'b0; m_sent <= 1'b1;
            end else if (m_busy && Retransmit) begin
                m_busy <= 1'b0;
                if (m_fail[m_cur] + 1 >= MAXR) begin
                    m_used[m_cur] <= 1'b0; m_drop <= 1'b1;
                end else m_fail[m_cur] <= m_fail[m_cur] + 1;
            end else if (!m_busy && data_in_req && nx >= 0) begin
                m_busy <= 1'b1; m_cur <= nx; m_txid <= m_id[nx]; m_pkt <= m_dat[nx];
            end
        end
    end

    always @(negedge clock) if (checking) begin
        check("wr_ready",   64'(wr_ready),   64'(count_used() < DEPTH));
        check("tx_pending", 64'(tx_pending), 64'(pick_next() >= 0));
        check("in_flight",  64'(in_flight),  64'(m_busy));
        check("Tx_ID",      64'(Tx_ID),      64'(m_txid));
        check("In_packet",  In_packet,       m_pkt);
        check("sent_pulse", 64'(sent_pulse), 64'(m_sent));
        check("drop_pulse", 64'(drop_pulse), 64'(m_drop));
        check("occupancy",  64'(occupancy),  64'(count_used()));
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    function automatic logic [63:0] pay(input int id);
        return 64'hC0DE_0000_0000_0000 | (64'(id) * 64'd977);
    endfunction

    task automatic put(input int id);
        wr_valid = 1'b1; wr_id = IS'(id); wr_data = pay(id);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic req();
        data_in_req = 1'b1; tick(); data_in_req = 1'b0;
    endtask

    task automatic done();
        tx_done = 1'b1; tick(); tx_done = 1'b0;
    endtask

    task automatic retx();
        Retransmit = 1'b1; tick(); Retransmit = 1'b0;
    endtask

    initial begin
        int order1 [4] = '{'h001, 'h10A, 'h111, 'h7FF};
        int order2 [4] = '{'h005, 'h020, 'h030, 'h040};
        int sent_seen;
        tick(); tick();
        reset = 1'b1;
        tick();
        checking = 1'b1;
        check("rst_wr_ready", 64'(wr_ready), 64'd1);
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_txid", 64'(Tx_ID), 64'd0);

        // Priority order
        put('h111); put('h001); put('h7FF); put('h10A);
        check("occ_full", 64'(occupancy), 64'd4);
        sent_seen = 0;
        for (int k = 0; k < 4; k++) begin
            req();
            check("order_id", 64'(Tx_ID), 64'(order1[k]));
            check("order_pkt", In_packet, pay(order1[k]));
            done();
            sent_seen += int'(sent_pulse);
            check("order_occ", 64'(occupancy), 64'(3 - k));
        end
        check("sent_count", 64'(sent_seen), 64'd4);

        // Full mailbox, write held across a retire
        put('h10); put('h20); put('h30); put('h40);
        check("full_ready", 64'(wr_ready), 64'd0);
        wr_valid = 1'b1; wr_id = IS'('h005); wr_data = pay('h005);
        tick();
        check("full_reject", 64'(occupancy), 64'd4);
        data_in_req = 1'b1; tick(); data_in_req = 1'b0;
        check("full_hand", 64'(Tx_ID), 64'h10);
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        check("retire_occ", 64'(occupancy), 64'd3);
        check("retire_ready", 64'(wr_ready), 64'd1);
        tick();
        wr_valid = 1'b0;
        check("refill_occ", 64'(occupancy), 64'd4);
        for (int k = 0; k < 4; k++) begin
            req(); check("drain_id", 64'(Tx_ID), 64'(order2[k])); done();
        end

        // Retry limit
        put('h123);
        for (int k = 0; k < MAXR; k++) begin
            req();
            check("retry_id", 64'(Tx_ID), 64'h123);
            check("retry_flight", 64'(in_flight), 64'd1);
            retx();
            if (k < MAXR - 1) check("retry_pend", 64'(tx_pending), 64'd1);
        end
        check("drop_pulse_lit", 64'(drop_pulse), 64'd1);
        check("drop_occ", 64'(occupancy), 64'd0);
        check("drop_pend", 64'(tx_pending), 64'd0);
        tick();
        check("drop_one_cycle", 64'(drop_pulse), 64'd0);

        // Overtake after Retransmit
        put('h200); req(); put('h050); retx();
        req(); check("overtake", 64'(Tx_ID), 64'h050); done();
        req(); check("follow", 64'(Tx_ID), 64'h200); done();

        // tx_done and Retransmit together
        put('h300); req();
        tx_done = 1'b1; Retransmit = 1'b1; tick(); tx_done = 1'b0; Retransmit = 1'b0;
        check("both_sent", 64'(sent_pulse), 64'd1);
        check("both_drop", 64'(drop_pulse), 64'd0);
        req();
        check("empty_req_flight", 64'(in_flight), 64'd0);
        check("empty_req_id", 64'(Tx_ID), 64'h300);
        put('h400); put('h010); req(); req();
        check("busy_req_id", 64'(Tx_ID), 64'h010);
        done(); req(); done();

        // Reset mid-transfer
        put('h001); put('h002); put('h003); put('h004); req();
        reset = 1'b0;
        #1;
        check("mid_rst_flight", 64'(in_flight), 64'd0);
        check("mid_rst_occ", 64'(occupancy), 64'd0);
        check("mid_rst_ready", 64'(wr_ready), 64'd1);
        check("mid_rst_pend", 64'(tx_pending), 64'd0);
        check("mid_rst_id", 64'(Tx_ID), 64'd0);
        check("mid_rst_pulse", 64'(sent_pulse | drop_pulse), 64'd0);
        tick(); tick();
        reset = 1'b1;
        tick();
        req();
        check("post_rst_req", 64'(in_flight), 64'd0);
        tick();
        checking = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/can_tx_mailbox.md
# can_tx_mailbox

Host-side transmit mailbox sitting directly upstream of a `can` node. Buffers up to `DEPTH` outgoing frames written by the host, answers the node's `data_in_req` with the highest-priority pending frame (lowest identifier, matching bus arbitration order), and re-queues a frame when the node raises `Retransmit`. Frames are retired on successful transmission or after `MAX_RETRY` failed attempts.

## Interface
- `DATA_SIZE`, 64, payload width; matches the node's `In_packet`.
- `ID_SIZE`, 11, identifier width; matches the node's `Tx_ID`.
- `DEPTH`, 4, number of mailbox slots (≥2).
- `MAX_RETRY`, 8, failed attempts before a frame is dropped (1..255).

- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low (asserted at 0).
- `wr_valid` in 1: host offers a frame.
- `wr_ready` out 1: a free slot exists; write accepted when `wr_valid && wr_ready` at a rising edge.
- `wr_id` in ID_SIZE: identifier of offered frame.
- `wr_data` in DATA_SIZE: payload of offered frame.
- `data_in_req` in 1: node requests the next frame.
- `In_packet` out DATA_SIZE: payload presented to the node.
- `Tx_ID` out ID_SIZE: identifier presented to the node.
- `tx_pending` out 1: at least one slot is valid and not in flight.
- `in_flight` out 1: a frame has been handed to the node and is unresolved.
- `Retransmit` in 1: node lost arbitration or saw an error on the in-flight frame.
- `tx_done` in 1: node completed the in-flight frame (ACK received).
- `sent_pulse` out 1: one-cycle pulse, frame retired on success.
- `drop_pulse` out 1: one-cycle pulse, frame retired after `MAX_RETRY` failures.
- `occupancy` out $clog2(DEPTH+1): count of valid slots (pending + in flight).

## Operation
- Per-slot state: `valid`, `id`, `data`, `retry_cnt` (8 bits). A global `in_flight` flag and `sel_idx` register name the handed-over slot.
- Write: accepted frame goes to the lowest-index free slot, `retry_cnt`=0. `wr_ready` = any slot free. No duplicate-ID check.
- Selection: among valid slots not in flight, pick the minimum `id`; ties go to the lowest index. Combinational, recomputed every cycle.
- Handover: `data_in_req` with `in_flight`=0 and a pending frame → register selected slot's data/id onto `In_packet`/`Tx_ID`, set `in_flight`, store `sel_idx`. The slot stays valid.
- `data_in_req` with `in_flight`=1: ignored, outputs held. With no pending frame: ignored, outputs held, `in_flight` stays 0.
- `tx_done` while in flight: clear slot `sel_idx`, clear `in_flight`, pulse `sent_pulse`.
- `Retransmit` while in flight: `retry_cnt`+1. If the new count equals `MAX_RETRY`: clear slot, pulse `drop_pulse`. Otherwise the slot returns to pending and is re-arbitrated at the next `data_in_req`; a newly written lower-ID frame overtakes it.
- `tx_done` and `Retransmit` in the same cycle: `tx_done` wins, `Retransmit` is discarded.
- `tx_done`/`Retransmit` with `in_flight`=0: ignored.
- Write and retire in the same cycle: the write uses the free-slot set from before the edge; the freed slot becomes available next cycle. When full, `wr_ready` rises one cycle after a retire.
- `Tx_ID`/`In_packet` keep their last value after retire; the node qualifies them with its own request.

## Timing
- Reset (asynchronous assert, synchronous release): all `valid`=0, `retry_cnt`=0, `in_flight`=0, `sel_idx`=0, `In_packet`=0, `Tx_ID`=0, `sent_pulse`=0, `drop_pulse`=0, `occupancy`=0, `tx_pending`=0, `wr_ready`=1.
- Reset mid-transfer discards all frames; no pulses are produced.
- A write at edge t is visible to selection and `tx_pending` from t+1. It can be handed over by a `data_in_req` sampled at t+1.
- `data_in_req` sampled at edge t → `In_packet`/`Tx_ID`/`in_flight` valid after t (1-cycle latency).
- `tx_done`/`Retransmit` at edge t → slot state, `occupancy`, and pulses updated after t. The pulses last exactly one cycle.
- `wr_ready`, `tx_pending`, and `occupancy` are registered-state derived, with no combinational path from inputs.

## Test plan
- Write IDs 0x111, 0x001, 0x7FF, 0x10A. Pulse `data_in_req` → `Tx_ID`=0x001 after one cycle. Repeat with `tx_done` → order 0x001, 0x10A, 0x111, 0x7FF, four `sent_pulse`, `occupancy` 4→0.
- Fill 4 slots → `wr_ready`=0, fifth write not accepted. Retire one with `tx_done` while holding `wr_valid` → write accepted one cycle later, `occupancy` stays 4.
- Single frame 0x123 with `Retransmit` after each handover, `MAX_RETRY`=8 → 7 re-handovers of 0x123, then `drop_pulse` on the 8th failure, `occupancy`=0, `tx_pending`=0.
- Frame 0x200 in flight. Write 0x050, then `Retransmit` → next `data_in_req` presents 0x050. 0x200 follows after `tx_done`.
- `tx_done` and `Retransmit` together → `sent_pulse` only, retry count unaffected. `data_in_req` while in flight and with an empty mailbox → outputs unchanged.
- Assert `reset`=0 with 3 frames pending and one in flight → all outputs reach reset values immediately, with no pulse. After release, first `data_in_req` → no handover.
